// File: rtl/i2c_byte_sender_if.sv
// Byte-sender bus: block push from the output distributor, byte handshake
// with the I2C controller, and status pulses.
//   slave  : view used by i2c_byte_sender (consumes requests, drives bytes/status)
//   master : view used by the controlling side (drives requests, observes bytes/status)
interface i2c_byte_sender_if;
    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 2;

    logic [BLOCK_W-1:0] block_in;
    logic               block_valid;
    logic               tx_req;
    logic               master_ack;
    logic               master_nack;
    logic               i2c_stop;
    logic [BYTE_W-1:0]  tx_data;
    logic               tx_valid;
    logic [CNT_W-1:0]   blocks_held;
    logic               underflow;
    logic               overflow;
    logic               short_read;

    modport slave (
        input  block_in, block_valid, tx_req, master_ack, master_nack, i2c_stop,
        output tx_data, tx_valid, blocks_held, underflow, overflow, short_read
    );

    modport master (
        output block_in, block_valid, tx_req, master_ack, master_nack, i2c_stop,
        input  tx_data, tx_valid, blocks_held, underflow, overflow, short_read
    );
endinterface

// File: rtl/i2c_byte_sender.sv
// Transmit-side byte serializer: buffers up to two 64-bit blocks and hands
// them out MSB-first, one byte per tx_req/ack handshake.
// Ports:
//   clk    : rising-edge clock
//   n_rst  : synchronous reset, active-high
//   bus    : slave view of i2c_byte_sender_if (block push, byte handshake,
//            tx_data/tx_valid, blocks_held and underflow/overflow/short_read)
module i2c_byte_sender (
    input  logic               clk,
    input  logic               n_rst,
    i2c_byte_sender_if.slave   bus
);
    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned SH_W    = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESENT  = 2'd1,
        WAIT_ACK = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BLOCK_W-1:0] mem_q [DEPTH];
    logic [BLOCK_W-1:0] mem_d [DEPTH];
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic               dummy_q, dummy_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               underflow_q, underflow_d;
    logic               overflow_q, overflow_d;
    logic               short_read_q, short_read_d;

    logic               pop;
    logic               push;
    logic [BLOCK_W-1:0] head;
    logic [SH_W-1:0]    shamt;

    // Next-state, buffer and output computation
    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        byte_idx_d   = byte_idx_q;
        dummy_d      = dummy_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = 1'b0;
        underflow_d  = 1'b0;
        overflow_d   = 1'b0;
        short_read_d = 1'b0;
        pop          = 1'b0;
        push         = 1'b0;

        head  = mem_q[rd_ptr_q];
        // Byte 0 is bits [63:56], so the shift is 8*(7-byte_idx)
        shamt = {IDX_W'(IDX_W'(7) - byte_idx_q), 3'b000};

        if (bus.i2c_stop) begin
            // STOP overrides any ack/nack; drop a block that was started
            if ((byte_idx_q != '0) || ((state_q != IDLE) && !dummy_q)) begin
                if (count_q != '0) begin
                    pop          = 1'b1;
                    short_read_d = 1'b1;
                end
                byte_idx_d = '0;
            end
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.tx_req) begin
                        tx_valid_d = 1'b1;
                        state_d    = PRESENT;
                        if (count_q != '0) begin
                            tx_data_d = head[shamt +: BYTE_W];
                            dummy_d   = 1'b0;
                        end else begin
                            tx_data_d   = 8'hFF;
                            dummy_d     = 1'b1;
                            underflow_d = 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    state_d = WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.master_ack) begin
                        if (!dummy_q) begin
                            if (byte_idx_q == IDX_W'(7)) begin
                                pop        = 1'b1;
                                byte_idx_d = '0;
                            end else begin
                                byte_idx_d = byte_idx_q + IDX_W'(1);
                            end
                        end
                        state_d = IDLE;
                    end else if (bus.master_nack) begin
                        if (!dummy_q) begin
                            pop          = 1'b1;
                            byte_idx_d   = '0;
                            short_read_d = (byte_idx_q != IDX_W'(7));
                        end
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A full buffer still accepts a push when the head is leaving this cycle
        push       = bus.block_valid && ((count_q != CNT_W'(DEPTH)) || pop);
        overflow_d = bus.block_valid && !push;
        if (push) begin
            mem_d[wr_ptr_q] = bus.block_in;
        end
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= '0;
            byte_idx_q   <= '0;
            dummy_q      <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
            short_read_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            byte_idx_q   <= byte_idx_d;
            dummy_q      <= dummy_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            underflow_q  <= underflow_d;
            overflow_q   <= overflow_d;
            short_read_q <= short_read_d;
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.blocks_held = count_q;
    assign bus.underflow   = underflow_q;
    assign bus.overflow    = overflow_q;
    assign bus.short_read  = short_read_q;
endmodule

// File: tb/tb_i2c_byte_sender.sv
// Directed bench for i2c_byte_sender: full-block reads, underflow, overflow,
// push during pop, early NACK, STOP mid-block and reset mid-transfer.
module tb_i2c_byte_sender;
    localparam logic [63:0] BLK_A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] BLK_B = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] BLK_C = 64'h1122_3344_5566_7788;

    localparam int RESP_ACK  = 0;
    localparam int RESP_NACK = 1;
    localparam int RESP_NONE = 2;

    logic clk;
    logic n_rst;
    int   checks;
    int   errors;

    logic [7:0] a_bytes [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

    i2c_byte_sender_if bus ();

    i2c_byte_sender dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] blk);
        bus.block_in    = blk;
        bus.block_valid = 1'b1;
        cyc();
        bus.block_valid = 1'b0;
    endtask

    // One byte: request, check presented byte, then respond
    task automatic xfer(input logic [7:0] exp, input string tag, input int resp);
        bus.tx_req = 1'b1;
        cyc();
        bus.tx_req = 1'b0;
        chk({tag, "_valid"}, 64'(bus.tx_valid), 64'd1);
        chk({tag, "_data"}, 64'(bus.tx_data), 64'(exp));
        cyc();
        chk({tag, "_valid_low"}, 64'(bus.tx_valid), 64'd0);
        if (resp == RESP_ACK) begin
            bus.master_ack = 1'b1;
            cyc();
            bus.master_ack = 1'b0;
        end else if (resp == RESP_NACK) begin
            bus.master_nack = 1'b1;
            cyc();
            bus.master_nack = 1'b0;
        end
    endtask

    task automatic read_block(input logic [63:0] blk, input string tag);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) begin
            v = blk >> (56 - 8 * i);
            xfer(8'(v), $sformatf("%s_b%0d", tag, i), RESP_ACK);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        n_rst           = 1'b1;
        bus.block_in    = '0;
        bus.block_valid = 1'b0;
        bus.tx_req      = 1'b0;
        bus.master_ack  = 1'b0;
        bus.master_nack = 1'b0;
        bus.i2c_stop    = 1'b0;
        cyc();
        cyc();
        n_rst = 1'b0;

        // Reset state
        chk("rst_tx_data", 64'(bus.tx_data), 64'h00);
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("rst_held", 64'(bus.blocks_held), 64'd0);
        chk("rst_underflow", 64'(bus.underflow), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_short", 64'(bus.short_read), 64'd0);

        // Full block, all ACKs
        push(BLK_A);
        chk("t1_held1", 64'(bus.blocks_held), 64'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("t1_held_before_last", 64'(bus.blocks_held), 64'd1);
            xfer(a_bytes[i], $sformatf("t1_b%0d", i), RESP_ACK);
        end
        chk("t1_held0", 64'(bus.blocks_held), 64'd0);

        // Underflow
        bus.tx_req = 1'b1;
        cyc();
        bus.tx_req = 1'b0;
        chk("t2_data", 64'(bus.tx_data), 64'hFF);
        chk("t2_valid", 64'(bus.tx_valid), 64'd1);
        chk("t2_underflow", 64'(bus.underflow), 64'd1);
        cyc();
        chk("t2_underflow_low", 64'(bus.underflow), 64'd0);
        chk("t2_valid_low", 64'(bus.tx_valid), 64'd0);
        bus.master_nack = 1'b1;
        cyc();
        bus.master_nack = 1'b0;
        chk("t2_held", 64'(bus.blocks_held), 64'd0);
        chk("t2_short", 64'(bus.short_read), 64'd0);

        // Overflow: C dropped
        push(BLK_A);
        push(BLK_B);
        chk("t3_overflow_pre", 64'(bus.overflow), 64'd0);
        push(BLK_C);
        chk("t3_overflow", 64'(bus.overflow), 64'd1);
        chk("t3_held2", 64'(bus.blocks_held), 64'd2);
        cyc();
        chk("t3_overflow_low", 64'(bus.overflow), 64'd0);
        read_block(BLK_A, "t3a");
        chk("t3_held1", 64'(bus.blocks_held), 64'd1);
        read_block(BLK_B, "t3b");
        chk("t3_held0", 64'(bus.blocks_held), 64'd0);

        // Push C on A's final ack: accepted, count stays 2
        push(BLK_A);
        push(BLK_B);
        for (int i = 0; i < 7; i++) begin
            xfer(a_bytes[i], $sformatf("t3r_b%0d", i), RESP_ACK);
        end
        xfer(a_bytes[7], "t3r_b7", RESP_NONE);
        bus.master_ack  = 1'b1;
        bus.block_in    = BLK_C;
        bus.block_valid = 1'b1;
        cyc();
        bus.master_ack  = 1'b0;
        bus.block_valid = 1'b0;
        chk("t3r_overflow", 64'(bus.overflow), 64'd0);
        chk("t3r_held2", 64'(bus.blocks_held), 64'd2);
        read_block(BLK_B, "t3rb");
        read_block(BLK_C, "t3rc");
        chk("t3r_held0", 64'(bus.blocks_held), 64'd0);

        // Early NACK on byte 2 of A
        push(BLK_A);
        push(BLK_B);
        xfer(8'h01, "t4_b0", RESP_ACK);
        xfer(8'h23, "t4_b1", RESP_ACK);
        xfer(8'h45, "t4_b2", RESP_NACK);
        chk("t4_short", 64'(bus.short_read), 64'd1);
        chk("t4_held1", 64'(bus.blocks_held), 64'd1);
        cyc();
        chk("t4_short_low", 64'(bus.short_read), 64'd0);
        xfer(8'hFE, "t4_nextb0", RESP_ACK);

        // STOP with ACK after 5 acked bytes of B
        push(BLK_C);
        chk("t5_held2", 64'(bus.blocks_held), 64'd2);
        xfer(8'hDC, "t5_b1", RESP_ACK);
        xfer(8'hBA, "t5_b2", RESP_ACK);
        xfer(8'h98, "t5_b3", RESP_ACK);
        xfer(8'h76, "t5_b4", RESP_ACK);
        xfer(8'h54, "t5_b5", RESP_NONE);
        bus.master_ack = 1'b1;
        bus.i2c_stop   = 1'b1;
        cyc();
        bus.master_ack = 1'b0;
        bus.i2c_stop   = 1'b0;
        chk("t5_short", 64'(bus.short_read), 64'd1);
        chk("t5_held1", 64'(bus.blocks_held), 64'd1);
        xfer(8'h11, "t5_c_b0", RESP_ACK);

        // Reset while awaiting ack with two blocks held
        push(BLK_A);
        chk("t6_held2", 64'(bus.blocks_held), 64'd2);
        xfer(8'h22, "t6_c_b1", RESP_NONE);
        n_rst = 1'b1;
        cyc();
        n_rst = 1'b0;
        chk("t6_tx_data", 64'(bus.tx_data), 64'h00);
        chk("t6_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("t6_held", 64'(bus.blocks_held), 64'd0);
        chk("t6_short", 64'(bus.short_read), 64'd0);
        chk("t6_underflow", 64'(bus.underflow), 64'd0);
        chk("t6_overflow", 64'(bus.overflow), 64'd0);
        bus.tx_req = 1'b1;
        cyc();
        bus.tx_req = 1'b0;
        chk("t6_uf_data", 64'(bus.tx_data), 64'hFF);
        chk("t6_uf_flag", 64'(bus.underflow), 64'd1);
        chk("t6_uf_valid", 64'(bus.tx_valid), 64'd1);
        cyc();
        bus.master_nack = 1'b1;
        cyc();
        bus.master_nack = 1'b0;
        chk("t6_held_end", 64'(bus.blocks_held), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
